alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter FIXED_PRIO, default 0, meaning 0 = round-robin arbitration and 1 = requester 0 always wins.
REQ-002 The block SHALL have parameter FLAGS_RST, default 4'b0000, meaning the reset value of the NZCV flag register.
REQ-003 The block SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have ports req0_valid / req1_valid  input  1  each meaning requester n presents an operation.
REQ-006 The block SHALL have ports req0_ready / req1_ready  output  1  each meaning requester n's operation is accepted this cycle.
REQ-007 The block SHALL have ports reqN_a, reqN_b  input  32  and reqN_op  input  4, meaning the operands and ALU op code of requester n.
REQ-008 The block SHALL have port reqN_setf  input  1  meaning the NZCV register is updated from this operation.
REQ-009 The block SHALL have ports alu_a, alu_b  output  32  and alu_op  output  4, meaning the operands driven to the shared ALU.
REQ-010 The block SHALL have port alu_result  input  32  and alu_z/alu_n/alu_c/alu_v  input  1 each, meaning the combinational outputs of the shared ALU.
REQ-011 The block SHALL have port rsp_valid  output  1  meaning a response is held.
REQ-012 The block SHALL have port rsp_ready  input  1  meaning the consumer takes the response.
REQ-013 The block SHALL have port rsp_id  output  1  meaning the requester that owns the response.
REQ-014 The block SHALL have port rsp_result  output  32  meaning the captured ALU result.
REQ-015 The block SHALL have port flags_nzcv  output  4  meaning the architectural flag register {N,Z,C,V}.

Function
REQ-016 The block SHALL have two states: EMPTY (no response held) and FULL (response held); rsp_valid SHALL equal (state==FULL).
REQ-017 can_accept SHALL be (state==EMPTY) or (rsp_valid and rsp_ready); a grant SHALL only be issued when can_accept is 1.
REQ-018 When only one requester is valid, that requester SHALL be granted; when neither is valid, there SHALL be no grant.
REQ-019 When both requesters are valid with FIXED_PRIO=0, the requester not recorded in last_grant SHALL win; last_grant SHALL update only on an actual grant.
REQ-020 When both requesters are valid with FIXED_PRIO=1, requester 0 SHALL always win.
REQ-021 At most one reqN_ready SHALL be high per cycle; ready SHALL be combinational from valid, last_grant and can_accept, and SHALL NOT depend on reqN_op or the operands.
REQ-022 alu_a/alu_b/alu_op SHALL mux the granted requester's fields combinationally; with no grant they SHALL be driven to 0.
REQ-023 On a grant, rsp_result, rsp_id and state=FULL SHALL be loaded at the clock edge; the response appears exactly 1 cycle after acceptance.
REQ-024 A drain and a new grant in the same cycle SHALL leave the state FULL with the new data, with no bubble, giving a throughput of 1 op/cycle.
REQ-025 A drain with no grant SHALL move the state to EMPTY; in FULL with rsp_ready=0, rsp_* SHALL hold stable and both ready outputs SHALL be 0.
REQ-026 On a grant with granted setf=1, flags_nzcv SHALL load {alu_n,alu_z,alu_c,alu_v} at the same edge; with setf=0, flags SHALL be unchanged.
REQ-027 Op codes 10-15 SHALL be forwarded unmodified; the result is whatever the ALU returns (0), and flags SHALL update if setf=1.
REQ-028 Requests SHALL NOT be buffered internally; a non-granted requester SHALL hold valid and its payload until ready.

Reset
REQ-029 When rst=1 at an edge, the block SHALL set state=EMPTY, rsp_valid=0, rsp_id=0, rsp_result=0, flags_nzcv=FLAGS_RST and last_grant=1 (so requester 0 wins the first tie).
REQ-030 While rst=1, req0_ready and req1_ready SHALL be 0; a reset asserted with a response held SHALL discard that response.

Verification
REQ-031 After reset, assert req0 ADD 5+3 with setf=1 -> req0_ready=1; the next cycle rsp_valid=1, rsp_id=0, rsp_result=8, flags=0000.
REQ-032 With both valid continuously and rsp_ready=1 (FIXED_PRIO=0) -> grants alternate 0,1,0,1; one response per cycle with no gaps.
REQ-033 Hold rsp_ready=0 for 3 cycles while req1 is valid -> req1_ready=0 and rsp_result is stable; raise rsp_ready -> req1 is granted in the same cycle.
REQ-034 req1 SUB 3-3 with setf=1 -> result 0 and flags=0110 (Z=1, C=1); a following req0 AND with setf=0 -> flags remain 0110.
REQ-035 Assert rst with rsp_valid=1 -> the next cycle rsp_valid=0 and flags=FLAGS_RST; with both requesters then valid, req0 is granted first.
REQ-036 With FIXED_PRIO=1 and both valid for 4 cycles -> req0 is granted every cycle and req1_ready stays 0.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester arbiter in front of a shared combinational ALU.
// The winner's operands go to the ALU in the same cycle. The result and the
// owner id are captured into a one-entry response register. The NZCV flag
// register is updated when the winning request asks for it. A response can
// drain in the same cycle as a new grant, so the block sustains one op per
// cycle.
module alu_arbiter #(
  parameter int         FIXED_PRIO = 0,
  parameter logic [3:0] FLAGS_RST  = 4'b0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [3:0]  req0_op,
  input  logic        req0_setf,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [3:0]  req1_op,
  input  logic        req1_setf,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_op,
  input  logic [31:0] alu_result,
  input  logic        alu_z,
  input  logic        alu_n,
  input  logic        alu_c,
  input  logic        alu_v,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_result,
  output logic [3:0]  flags_nzcv
);

  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  logic [0:0] state;
  logic       last_grant;
  logic       can_accept;
  logic       grant0;
  logic       grant1;
  logic       sel_setf;

  assign rsp_valid  = (state == FULL);
  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Arbitration: pick at most one requester, only when the response slot is free or draining.
  always_comb begin
    can_accept = (state == EMPTY) || ((state == FULL) && rsp_ready);
    grant0     = 1'b0;
    grant1     = 1'b0;
    if (rst || !can_accept) begin
      grant0 = 1'b0;
      grant1 = 1'b0;
    end else if (req0_valid && req1_valid) begin
      if (FIXED_PRIO != 0) begin
        grant0 = 1'b1;
      end else if (last_grant) begin
        grant0 = 1'b1;
      end else begin
        grant1 = 1'b1;
      end
    end else if (req0_valid) begin
      grant0 = 1'b1;
    end else if (req1_valid) begin
      grant1 = 1'b1;
    end else begin
      grant0 = 1'b0;
      grant1 = 1'b0;
    end
  end

  // Operand mux: the granted requester drives the shared ALU; idle drives zeros.
  always_comb begin
    alu_a    = 32'd0;
    alu_b    = 32'd0;
    alu_op   = 4'd0;
    sel_setf = 1'b0;
    case ({grant1, grant0})
      2'b01: begin
        alu_a    = req0_a;
        alu_b    = req0_b;
        alu_op   = req0_op;
        sel_setf = req0_setf;
      end
      2'b10: begin
        alu_a    = req1_a;
        alu_b    = req1_b;
        alu_op   = req1_op;
        sel_setf = req1_setf;
      end
      default: begin
        alu_a    = 32'd0;
        alu_b    = 32'd0;
        alu_op   = 4'd0;
        sel_setf = 1'b0;
      end
    endcase
  end

  // Response register, flag register and round-robin history.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= EMPTY;
      rsp_id     <= 1'b0;
      rsp_result <= 32'd0;
      flags_nzcv <= FLAGS_RST;
      last_grant <= 1'b1;
    end else if (grant0 || grant1) begin
      state      <= FULL;
      rsp_id     <= grant1;
      rsp_result <= alu_result;
      last_grant <= grant1;
      if (sel_setf) begin
        flags_nzcv <= {alu_n, alu_z, alu_c, alu_v};
      end else begin
        flags_nzcv <= flags_nzcv;
      end
    end else if ((state == FULL) && rsp_ready) begin
      state <= EMPTY;
    end else begin
      state <= state;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a round-robin instance driven by a table of vectors
// plus hand sequences, and a fixed-priority instance checked for priority.
module tb_alu_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req0_valid, req1_valid, req0_setf, req1_setf, rsp_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_op, req1_op;

  // round-robin instance signals
  logic        r0, r1, rvld, rid, az, an, ac, av;
  logic [31:0] aa, ab, ares, rres;
  logic [3:0]  aop, rflags;
  // fixed-priority instance signals
  logic        f0, f1, fvld, fid, fz, fn, fc, fv;
  logic [31:0] fa, fb, fres, frres;
  logic [3:0]  fop, fflags;

  int checks = 0;
  int failures = 0;

  // Reference ALU: op 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, others return 0.
  // Packed as {n, z, c, v, result}.
  function automatic logic [35:0] alu_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    logic [31:0] r;
    logic c, v;
    s = 33'd0; r = 32'd0; c = 1'b0; v = 1'b0;
    case (op)
      4'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[31:0]; c = s[32];
                  v = (a[31] == b[31]) && (r[31] != a[31]); end
      4'd1: begin r = a - b; c = (a >= b); v = (a[31] != b[31]) && (r[31] != a[31]); end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      default: r = 32'd0;
    endcase
    return {r[31], (r == 32'd0), c, v, r};
  endfunction

  assign {an, az, ac, av, ares} = alu_model(aop, aa, ab);
  assign {fn, fz, fc, fv, fres} = alu_model(fop, fa, fb);

  alu_arbiter #(.FIXED_PRIO(0)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(r0), .req0_a(req0_a), .req0_b(req0_b),
    .req0_op(req0_op), .req0_setf(req0_setf),
    .req1_valid(req1_valid), .req1_ready(r1), .req1_a(req1_a), .req1_b(req1_b),
    .req1_op(req1_op), .req1_setf(req1_setf),
    .alu_a(aa), .alu_b(ab), .alu_op(aop), .alu_result(ares),
    .alu_z(az), .alu_n(an), .alu_c(ac), .alu_v(av),
    .rsp_valid(rvld), .rsp_ready(rsp_ready), .rsp_id(rid), .rsp_result(rres),
    .flags_nzcv(rflags)
  );

  alu_arbiter #(.FIXED_PRIO(1), .FLAGS_RST(4'b1010)) dut_fp (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(f0), .req0_a(req0_a), .req0_b(req0_b),
    .req0_op(req0_op), .req0_setf(req0_setf),
    .req1_valid(req1_valid), .req1_ready(f1), .req1_a(req1_a), .req1_b(req1_b),
    .req1_op(req1_op), .req1_setf(req1_setf),
    .alu_a(fa), .alu_b(fb), .alu_op(fop), .alu_result(fres),
    .alu_z(fz), .alu_n(fn), .alu_c(fc), .alu_v(fv),
    .rsp_valid(fvld), .rsp_ready(rsp_ready), .rsp_id(fid), .rsp_result(frres),
    .flags_nzcv(fflags)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic v0; logic [3:0] op0; logic [31:0] a0; logic [31:0] b0; logic s0;
    logic v1; logic [3:0] op1; logic [31:0] a1; logic [31:0] b1; logic s1;
    logic rr;
    logic e_r0; logic e_r1; logic e_vld; logic e_id; logic [31:0] e_res; logic [3:0] e_flags;
  } vec_t;

  function automatic vec_t mk(
    input logic v0, input logic [3:0] op0, input logic [31:0] a0, input logic [31:0] b0, input logic s0,
    input logic v1, input logic [3:0] op1, input logic [31:0] a1, input logic [31:0] b1, input logic s1,
    input logic rr, input logic e_r0, input logic e_r1, input logic e_vld, input logic e_id,
    input logic [31:0] e_res, input logic [3:0] e_flags);
    vec_t t;
    t.v0 = v0; t.op0 = op0; t.a0 = a0; t.b0 = b0; t.s0 = s0;
    t.v1 = v1; t.op1 = op1; t.a1 = a1; t.b1 = b1; t.s1 = s1;
    t.rr = rr; t.e_r0 = e_r0; t.e_r1 = e_r1; t.e_vld = e_vld; t.e_id = e_id;
    t.e_res = e_res; t.e_flags = e_flags;
    return t;
  endfunction

  task automatic drive(input logic v0, input logic [3:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                       input logic s0, input logic v1, input logic [3:0] op1, input logic [31:0] a1,
                       input logic [31:0] b1, input logic s1, input logic rr);
    req0_valid = v0; req0_op = op0; req0_a = a0; req0_b = b0; req0_setf = s0;
    req1_valid = v1; req1_op = op1; req1_a = a1; req1_b = b1; req1_setf = s1;
    rsp_ready = rr;
  endtask

  vec_t vecs[15];

  initial begin
    // v0 op0 a0 b0 s0 | v1 op1 a1 b1 s1 | rr | r0 r1 | vld id res flags
    vecs[0]  = mk(1'b1, 4'd0, 32'd5, 32'd3, 1'b1,  1'b0, 4'd0, 32'd0, 32'd0, 1'b0,  1'b0,
                  1'b1, 1'b0, 1'b1, 1'b0, 32'd8, 4'b0000);
    vecs[1]  = mk(1'b0, 4'd0, 32'd0, 32'd0, 1'b0,  1'b1, 4'd1, 32'd3, 32'd3, 1'b1,  1'b1,
                  1'b0, 1'b1, 1'b1, 1'b1, 32'd0, 4'b0110);
    vecs[2]  = mk(1'b1, 4'd2, 32'hF0, 32'h3C, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0,  1'b1,
                  1'b1, 1'b0, 1'b1, 1'b0, 32'h30, 4'b0110);
    vecs[3]  = mk(1'b1, 4'd0, 32'd1, 32'd1, 1'b0,  1'b1, 4'd0, 32'd2, 32'd2, 1'b0,  1'b1,
                  1'b0, 1'b1, 1'b1, 1'b1, 32'd4, 4'b0110);
    vecs[4]  = mk(1'b1, 4'd0, 32'd1, 32'd1, 1'b0,  1'b1, 4'd0, 32'd2, 32'd2, 1'b0,  1'b1,
                  1'b1, 1'b0, 1'b1, 1'b0, 32'd2, 4'b0110);
    vecs[5]  = mk(1'b1, 4'd0, 32'd1, 32'd1, 1'b0,  1'b1, 4'd0, 32'd2, 32'd2, 1'b0,  1'b1,
                  1'b0, 1'b1, 1'b1, 1'b1, 32'd4, 4'b0110);
    vecs[6]  = mk(1'b1, 4'd0, 32'd1, 32'd1, 1'b0,  1'b1, 4'd0, 32'd2, 32'd2, 1'b0,  1'b1,
                  1'b1, 1'b0, 1'b1, 1'b0, 32'd2, 4'b0110);
    vecs[7]  = mk(1'b0, 4'd0, 32'd0, 32'd0, 1'b0,  1'b1, 4'd1, 32'd7, 32'd2, 1'b0,  1'b0,
                  1'b0, 1'b0, 1'b1, 1'b0, 32'd2, 4'b0110);
    vecs[8]  = mk(1'b0, 4'd0, 32'd0, 32'd0, 1'b0,  1'b1, 4'd1, 32'd7, 32'd2, 1'b0,  1'b0,
                  1'b0, 1'b0, 1'b1, 1'b0, 32'd2, 4'b0110);
    vecs[9]  = mk(1'b0, 4'd0, 32'd0, 32'd0, 1'b0,  1'b1, 4'd1, 32'd7, 32'd2, 1'b0,  1'b0,
                  1'b0, 1'b0, 1'b1, 1'b0, 32'd2, 4'b0110);
    vecs[10] = mk(1'b0, 4'd0, 32'd0, 32'd0, 1'b0,  1'b1, 4'd1, 32'd7, 32'd2, 1'b0,  1'b1,
                  1'b0, 1'b1, 1'b1, 1'b1, 32'd5, 4'b0110);
    vecs[11] = mk(1'b0, 4'd0, 32'd0, 32'd0, 1'b0,  1'b0, 4'd0, 32'd0, 32'd0, 1'b0,  1'b1,
                  1'b0, 1'b0, 1'b0, 1'b1, 32'd5, 4'b0110);
    vecs[12] = mk(1'b1, 4'd12, 32'd5, 32'd9, 1'b1, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0,  1'b1,
                  1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 4'b0100);
    vecs[13] = mk(1'b0, 4'd0, 32'd0, 32'd0, 1'b0,  1'b1, 4'd0, 32'h7FFFFFFF, 32'd1, 1'b1, 1'b1,
                  1'b0, 1'b1, 1'b1, 1'b1, 32'h80000000, 4'b1001);
    vecs[14] = mk(1'b1, 4'd0, 32'hFFFFFFFF, 32'd1, 1'b1, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b1,
                  1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 4'b0110);

    // Reset with requests pending: ready must stay low while rst is high.
    rst = 1'b1;
    drive(1'b1, 4'd0, 32'd1, 32'd1, 1'b0, 1'b1, 4'd0, 32'd2, 32'd2, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    check("rst_r0", {31'd0, r0}, 32'd0);
    check("rst_r1", {31'd0, r1}, 32'd0);
    check("rst_vld", {31'd0, rvld}, 32'd0);
    check("rst_id", {31'd0, rid}, 32'd0);
    check("rst_res", rres, 32'd0);
    check("rst_flags", {28'd0, rflags}, 32'd0);
    check("rst_fp_flags", {28'd0, fflags}, 32'h0000000A);
    rst = 1'b0;
    drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0);

    // Table-driven vectors on the round-robin instance.
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].v0, vecs[i].op0, vecs[i].a0, vecs[i].b0, vecs[i].s0,
            vecs[i].v1, vecs[i].op1, vecs[i].a1, vecs[i].b1, vecs[i].s1, vecs[i].rr);
      @(negedge clk);
      check($sformatf("v%0d_r0", i), {31'd0, r0}, {31'd0, vecs[i].e_r0});
      check($sformatf("v%0d_r1", i), {31'd0, r1}, {31'd0, vecs[i].e_r1});
      @(posedge clk);
      #1;
      check($sformatf("v%0d_vld", i), {31'd0, rvld}, {31'd0, vecs[i].e_vld});
      check($sformatf("v%0d_id", i), {31'd0, rid}, {31'd0, vecs[i].e_id});
      check($sformatf("v%0d_res", i), rres, vecs[i].e_res);
      check($sformatf("v%0d_flags", i), {28'd0, rflags}, {28'd0, vecs[i].e_flags});
    end

    // Reset while a response is held: it is discarded and flags return to reset value.
    check("pre_rst_vld", {31'd0, rvld}, 32'd1);
    rst = 1'b1;
    drive(1'b1, 4'd0, 32'd1, 32'd1, 1'b0, 1'b1, 4'd0, 32'd2, 32'd2, 1'b0, 1'b1);
    @(negedge clk);
    check("rst2_r0", {31'd0, r0}, 32'd0);
    check("rst2_r1", {31'd0, r1}, 32'd0);
    @(posedge clk);
    #1;
    check("rst2_vld", {31'd0, rvld}, 32'd0);
    check("rst2_flags", {28'd0, rflags}, 32'd0);
    check("rst2_res", rres, 32'd0);
    check("rst2_fp_flags", {28'd0, fflags}, 32'h0000000A);
    rst = 1'b0;

    // First tie after reset goes to requester 0.
    @(negedge clk);
    check("tie_r0", {31'd0, r0}, 32'd1);
    check("tie_r1", {31'd0, r1}, 32'd0);
    @(posedge clk);
    #1;
    check("tie_id", {31'd0, rid}, 32'd0);
    check("tie_res", rres, 32'd2);

    // Fixed-priority instance: requester 0 wins every cycle while both are valid.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("fp%0d_r0", k), {31'd0, f0}, 32'd1);
      check($sformatf("fp%0d_r1", k), {31'd0, f1}, 32'd0);
      @(posedge clk);
      #1;
      check($sformatf("fp%0d_vld", k), {31'd0, fvld}, 32'd1);
      check($sformatf("fp%0d_id", k), {31'd0, fid}, 32'd0);
      check($sformatf("fp%0d_res", k), frres, 32'd2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
